// File: rtl/alu_slice_array_if.sv
// Operand/result bus for alu_slice_array. With ALU_STICKY_OVF_EN defined the bus
// also carries clr_ovf and sticky_ovf.
interface alu_slice_array_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       cntrl;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;
`ifdef ALU_STICKY_OVF_EN
  logic             clr_ovf;
  logic             sticky_ovf;
`endif

  modport master (
    output in_valid, A, B, cntrl,
`ifdef ALU_STICKY_OVF_EN
    output clr_ovf,
    input  sticky_ovf,
`endif
    input  out_valid, result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  in_valid, A, B, cntrl,
`ifdef ALU_STICKY_OVF_EN
    input  clr_ovf,
    output sticky_ovf,
`endif
    output out_valid, result, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/alu_slice_array.sv
// Registered WIDTH-bit ripple ALU built from 1-bit cells, with NZVC flags.
// Optional ALU_STICKY_OVF_EN adds a sticky overflow bit cleared by clr_ovf.
module alu_cell (
  input  logic [2:0] cntrl,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  output logic       cout,
  output logic       res
);
  logic bb, sum;

  assign bb   = b ^ cntrl[0];
  assign sum  = a ^ bb ^ cin;
  assign cout = (a & bb) | (cin & (a ^ bb));

  always_comb begin
    res = 1'b0;
    unique case (cntrl)
      3'b000:         res = b;
      3'b010, 3'b011: res = sum;
      3'b100:         res = a & b;
      3'b101:         res = a | b;
      3'b110:         res = a ^ b;
      default:        res = 1'b0;
    endcase
  end
endmodule

module alu_slice_array #(parameter int WIDTH = 64) (
  input  logic               clk,
  input  logic               reset,
  alu_slice_array_if.slave   bus
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] res_c;
  logic             arith;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             negative_q, negative_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             carry_out_q, carry_out_d;

  // Subtract feeds the +1 of two's complement in through the bit-0 carry.
  assign carry[0] = bus.cntrl[0];
  assign arith    = (bus.cntrl[2:1] == 2'b01);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    alu_cell u_cell (
      .cntrl (bus.cntrl),
      .a     (bus.A[i]),
      .b     (bus.B[i]),
      .cin   (carry[i]),
      .cout  (carry[i+1]),
      .res   (res_c[i])
    );
  end

  always_comb begin
    out_valid_d = bus.in_valid;
    result_d    = result_q;
    negative_d  = negative_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    carry_out_d = carry_out_q;
    if (bus.in_valid) begin
      result_d    = res_c;
      negative_d  = res_c[WIDTH-1];
      zero_d      = ~|res_c;
      overflow_d  = arith & (carry[WIDTH] ^ carry[WIDTH-1]);
      carry_out_d = arith & carry[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      negative_q  <= negative_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.negative  = negative_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.carry_out = carry_out_q;

`ifdef ALU_STICKY_OVF_EN
  logic sticky_ovf_q, sticky_ovf_d;

  // Clear takes priority over a same-edge set.
  always_comb begin
    sticky_ovf_d = sticky_ovf_q | (bus.in_valid & arith & (carry[WIDTH] ^ carry[WIDTH-1]));
    if (bus.clr_ovf) sticky_ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) sticky_ovf_q <= 1'b0;
    else       sticky_ovf_q <= sticky_ovf_d;
  end

  assign bus.sticky_ovf = sticky_ovf_q;
`endif
endmodule

// File: tb/tb_alu_slice_array.sv
// Directed-vector bench for alu_slice_array (WIDTH=64), hand-computed expectations.
module tb_alu_slice_array;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  alu_slice_array_if #(.WIDTH(W)) bus();

  alu_slice_array #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Flags packed as {negative, zero, overflow, carry_out}.
  task automatic expect_out(input string tag, input logic [63:0] res, input logic [3:0] flg,
                            input logic vld);
    check({tag, ".result"}, bus.result, res);
    check({tag, ".flags"}, {60'd0, bus.negative, bus.zero, bus.overflow, bus.carry_out},
          {60'd0, flg});
    check({tag, ".out_valid"}, {63'd0, bus.out_valid}, {63'd0, vld});
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] c);
    bus.A = a; bus.B = b; bus.cntrl = c; bus.in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.A = 64'h1234; bus.B = 64'h5678; bus.cntrl = 3'b010;
`ifdef ALU_STICKY_OVF_EN
    bus.clr_ovf = 1'b0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_out("reset", 64'd0, 4'b0000, 1'b0);
    reset = 1'b0;

    // Back-to-back issue: each result checked one edge after its operands.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
    expect_out("add_carry", 64'd0, 4'b0101, 1'b1);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
    expect_out("add_ovf", 64'h8000_0000_0000_0000, 4'b1010, 1'b1);
`ifdef ALU_STICKY_OVF_EN
    check("sticky_set", {63'd0, bus.sticky_ovf}, 64'd1);
`endif
    issue(64'd5, 64'd7, 3'b011);
    expect_out("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b1);
`ifdef ALU_STICKY_OVF_EN
    check("sticky_hold", {63'd0, bus.sticky_ovf}, 64'd1);
`endif
    issue(64'd7, 64'd7, 3'b011);
    expect_out("sub_zero", 64'd0, 4'b0101, 1'b1);
    issue(64'h8000_0000_0000_0000, 64'd1, 3'b011);
    expect_out("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b1);
`ifdef ALU_STICKY_OVF_EN
    bus.clr_ovf = 1'b1;
`endif
    issue(64'hF0F0, 64'hFF00, 3'b100);
    expect_out("and", 64'hF000, 4'b0000, 1'b1);
`ifdef ALU_STICKY_OVF_EN
    check("sticky_clr", {63'd0, bus.sticky_ovf}, 64'd0);
    bus.clr_ovf = 1'b0;
`endif
    issue(64'hF0F0, 64'hFF00, 3'b101);
    expect_out("or", 64'hFFF0, 4'b0000, 1'b1);
    issue(64'hF0F0, 64'hFF00, 3'b110);
    expect_out("xor", 64'h0FF0, 4'b0000, 1'b1);
    issue(64'hF0F0, 64'hFF00, 3'b000);
    expect_out("pass_b", 64'hFF00, 4'b0000, 1'b1);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111);
    expect_out("undef_111", 64'd0, 4'b0100, 1'b1);
    issue(64'hF0F0, 64'h8000_0000_0000_FF00, 3'b000);
    expect_out("pass_neg", 64'h8000_0000_0000_FF00, 4'b1000, 1'b1);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001);
    expect_out("undef_001", 64'd0, 4'b0100, 1'b1);
    issue(64'h1, 64'h8000_0000_0000_0001, 3'b101);
    expect_out("or_neg", 64'h8000_0000_0000_0001, 4'b1000, 1'b1);

    // Idle: out_valid drops, data and flags hold.
    bus.in_valid = 1'b0;
    bus.A = 64'd3; bus.B = 64'd4; bus.cntrl = 3'b010;
    @(posedge clk); #1;
    expect_out("hold1", 64'h8000_0000_0000_0001, 4'b1000, 1'b0);
    @(posedge clk); #1;
    expect_out("hold2", 64'h8000_0000_0000_0001, 4'b1000, 1'b0);

    // Mid-stream reset beats a valid op, then first op after reset is normal.
    reset = 1'b1;
    issue(64'd9, 64'd9, 3'b010);
    expect_out("reset_wins", 64'd0, 4'b0000, 1'b0);
    reset = 1'b0;
    issue(64'd2, 64'd3, 3'b010);
    expect_out("post_reset", 64'd5, 4'b0000, 1'b1);
`ifdef ALU_STICKY_OVF_EN
    // Same-edge set and clear: clear wins.
    bus.clr_ovf = 1'b1;
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
    check("sticky_clr_wins", {63'd0, bus.sticky_ovf}, 64'd0);
    bus.clr_ovf = 1'b0;
`endif
    bus.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
